onn_sequencer: RTL and testbench

ONN_SEQUENCER -- requirements
Module: onn_sequencer

---
 rtl/onn_pkg.sv | 7 +
 rtl/onn_popcount.sv | 13 +
 rtl/onn_sequencer.sv | 92 +++++++++
 tb/tb_onn_sequencer.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/onn_pkg.sv
// onn_pkg: shared state encoding and default sizing for the ONN recall sequencer
package onn_pkg;
  typedef enum logic [2:0] {IDLE, RST, GAP, DROP, SETTLE, CHECK, EVAL, DONE} state_e;
  localparam int N_NEURONS_DEF     = 15;
  localparam int SETTLE_CYCLES_DEF = 16;
  localparam int MAX_ITER_DEF      = 64;
endpackage

// File: rtl/onn_popcount.sv
// onn_popcount: combinational population count (bits_i: W flags in, cnt_o: number of set flags out)
module onn_popcount #(
  parameter int W = 15
) (
  input  logic [W-1:0]             bits_i,
  output logic [$clog2(W+1)-1:0]   cnt_o
);
  localparam int CW = $clog2(W + 1);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) cnt_o = cnt_o + CW'(bits_i[i]);
  end
endmodule

// File: rtl/onn_sequencer.sv
// onn_sequencer: recall sequencer for ONN phase registers (in: start/abort/state_changed; out: phase_re/drop/check pulses, busy, done, converged, iter_count, changed_cnt)
module onn_sequencer
  import onn_pkg::*;
#(
  parameter int N_NEURONS     = N_NEURONS_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int MAX_ITER      = MAX_ITER_DEF
) (
  input  logic                               clk,
  input  logic                               re,
  input  logic                               start,
  input  logic                               abort,
  input  logic [N_NEURONS-1:0]               state_changed,
  output logic                               phase_re,
  output logic                               phase_drop,
  output logic                               phase_check,
  output logic                               busy,
  output logic                               done,
  output logic                               converged,
  output logic [6:0]                         iter_count,
  output logic [$clog2(N_NEURONS+1)-1:0]     changed_cnt
);
  localparam int CW = $clog2(N_NEURONS + 1);
  state_e        state_q, state_d;
  logic [7:0]    settle_q;
  logic [6:0]    iter_q;
  logic [CW-1:0] changed_q, pop;
  logic          re_q, drop_q, check_q, busy_q, done_q, conv_q;
  logic          any;

  onn_popcount #(.W(N_NEURONS)) u_pop (.bits_i(state_changed), .cnt_o(pop));

  assign any = |state_changed;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? RST : IDLE;
      RST:     state_d = GAP;
      GAP:     state_d = DROP;
      DROP:    state_d = SETTLE;
      SETTLE:  state_d = (settle_q == 8'd0) ? CHECK : SETTLE;
      CHECK:   state_d = EVAL;
      EVAL:    state_d = (any && iter_q < 7'(MAX_ITER)) ? SETTLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  // Outputs are registered from the next state so each pulse lines up with its state.
  always_ff @(posedge clk) begin
    if (re) begin
      state_q   <= IDLE;
      settle_q  <= '0;
      iter_q    <= '0;
      changed_q <= '0;
      re_q      <= 1'b0;
      drop_q    <= 1'b0;
      check_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      conv_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      re_q     <= state_d == RST;
      drop_q   <= state_d == DROP;
      check_q  <= state_d == CHECK;
      busy_q   <= state_d != IDLE;
      done_q   <= state_d == DONE;
      settle_q <= (state_q == SETTLE) ? settle_q - 8'd1 : 8'(SETTLE_CYCLES - 1);
      if (state_q == IDLE && state_d == RST) begin
        iter_q    <= '0;
        changed_q <= '0;
      end else if (state_d == CHECK) begin
        iter_q <= iter_q + 7'd1;
      end
      if (state_q == EVAL) changed_q <= pop;
      if (abort && state_q != IDLE) conv_q <= 1'b0;
      else if (state_q == EVAL && state_d == DONE) conv_q <= !any;
    end
  end

  assign phase_re    = re_q;
  assign phase_drop  = drop_q;
  assign phase_check = check_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign converged   = conv_q;
  assign iter_count  = iter_q;
  assign changed_cnt = changed_q;
endmodule

// File: tb/tb_onn_sequencer.sv
// tb_onn_sequencer: directed self-checking bench for onn_sequencer
module tb_onn_sequencer;
  logic        clk = 1'b0;
  logic        re = 1'b1, start = 1'b0, abort = 1'b0;
  logic [14:0] sc = '0;
  logic        phase_re, phase_drop, phase_check, busy, done, converged;
  logic [6:0]  iter_count;
  logic [3:0]  changed_cnt;
  logic        start1 = 1'b0;
  logic [14:0] sc1 = '1;
  logic        p1_re, p1_drop, p1_chk, p1_busy, p1_done, p1_conv;
  logic [6:0]  p1_iter;
  logic [3:0]  p1_cnt;
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  onn_sequencer dut (
    .clk(clk), .re(re), .start(start), .abort(abort), .state_changed(sc),
    .phase_re(phase_re), .phase_drop(phase_drop), .phase_check(phase_check),
    .busy(busy), .done(done), .converged(converged),
    .iter_count(iter_count), .changed_cnt(changed_cnt)
  );

  onn_sequencer #(.SETTLE_CYCLES(1), .MAX_ITER(2)) dut1 (
    .clk(clk), .re(re), .start(start1), .abort(1'b0), .state_changed(sc1),
    .phase_re(p1_re), .phase_drop(p1_drop), .phase_check(p1_chk),
    .busy(p1_busy), .done(p1_done), .converged(p1_conv),
    .iter_count(p1_iter), .changed_cnt(p1_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_chk(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!phase_check && n < 300);
  endtask

  task automatic run_clean();
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("re_pulse", 32'(phase_re), 1);
    chk("busy_run", 32'(busy), 1);
    tick();
    chk("gap_low", 32'({phase_re, phase_drop, phase_check}), 0);
    tick();
    chk("drop_pulse", 32'(phase_drop), 1);
    wait_chk(n);
    chk("drop_to_check", 32'(n), 17);
    chk("iter_at_check", 32'(iter_count), 1);
    tick();
    tick();
    chk("clean_done", 32'(done), 1);
    chk("clean_conv", 32'(converged), 1);
    chk("clean_iter", 32'(iter_count), 1);
    chk("clean_cnt", 32'(changed_cnt), 0);
    tick();
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_after_done", 32'(busy), 0);
  endtask

  always @(negedge clk) chk("pulse_excl", 32'($onehot0({phase_re, phase_drop, phase_check})), 1);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, nchk, ndone;
    repeat (3) tick();
    re = 1'b0;
    chk("reset_outs", 32'({phase_re, phase_drop, phase_check, busy, done, converged, iter_count, changed_cnt}), 0);

    run_clean();

    sc = '1;
    start = 1'b1;
    tick();
    start = 1'b0;
    nchk = 0;
    ndone = 0;
    for (int i = 0; i < 2000 && ndone == 0; i++) begin
      tick();
      nchk += int'(phase_check);
      ndone += int'(done);
    end
    chk("sat_checks", 32'(nchk), 64);
    chk("sat_conv", 32'(converged), 0);
    chk("sat_iter", 32'(iter_count), 64);
    chk("sat_cnt", 32'(changed_cnt), 15);
    repeat (5) begin
      tick();
      ndone += int'(done);
    end
    chk("sat_done_once", 32'(ndone), 1);

    sc = 15'h0007;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    wait_chk(n);
    chk("p3_first", 32'(n), 17);
    for (int i = 2; i <= 4; i++) begin
      tick();
      tick();
      chk("p3_cnt", 32'(changed_cnt), 3);
      if (i == 4) sc = '0;
      wait_chk(n);
      chk("p3_spacing", 32'(n + 2), 18);
    end
    tick();
    tick();
    chk("p3_done", 32'(done), 1);
    chk("p3_conv", 32'(converged), 1);
    chk("p3_iter", 32'(iter_count), 4);
    chk("p3_cnt_final", 32'(changed_cnt), 0);
    tick();

    sc = 15'h0001;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    wait_chk(n);
    tick();
    tick();
    wait_chk(n);
    repeat (4) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_conv", 32'(converged), 0);
    chk("abort_iter", 32'(iter_count), 2);
    ndone = 0;
    repeat (30) begin
      tick();
      ndone += int'(done) + int'(busy);
    end
    chk("abort_quiet", 32'(ndone), 0);

    sc = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    wait_chk(n);
    re = 1'b1;
    tick();
    re = 1'b0;
    chk("re_mid_outs", 32'({phase_re, phase_drop, phase_check, busy, done, converged, iter_count, changed_cnt}), 0);
    run_clean();

    start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      n = 0;
      while (!done && n < 100) begin
        tick();
        n++;
      end
      chk("b2b_done_seen", 32'(done), 1);
      tick();
      chk("b2b_idle_gap", 32'(busy), 0);
      tick();
      chk("b2b_relaunch", 32'(phase_re), 1);
    end
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    chk("b2b_last_done", 32'(done), 1);
    tick();

    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    tick();
    chk("s1_drop", 32'(p1_drop), 1);
    n = 0;
    do begin
      tick();
      n++;
    end while (!p1_chk && n < 50);
    chk("s1_settle_len", 32'(n), 2);
    nchk = 1;
    for (int i = 0; i < 50 && !p1_done; i++) begin
      tick();
      nchk += int'(p1_chk);
    end
    chk("s1_done", 32'(p1_done), 1);
    chk("s1_checks", 32'(nchk), 2);
    chk("s1_iter", 32'(p1_iter), 2);
    chk("s1_conv", 32'(p1_conv), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
